program_loader: RTL

Upstream boot stage for the 4-bit CPU. Receives an assembled program as a byte stream over a valid/ready handshake, checks length and checksum, and writes it into the CPU's 16x4 instruction memory, low nibble first. Unused words are padded with NOP (0). The CPU is held in reset until a load completes cleanly, then released.

---
 rtl/program_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-stage loader: receives a length/bytes/checksum stream over valid/ready,
// writes the program into the 16x4 instruction memory low nibble first,
// pads unused words with NOP, and releases the CPU only after a clean load.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   load_start_i         begin a load from IDLE, DONE or ERR
//   in_valid_i/in_data_i stream byte {operand, opcode}
//   in_ready_o           byte accepted this cycle when in_valid_i is high
//   mem_we_o/mem_addr_o/mem_wdata_o  instruction-memory nibble write port
//   cpu_reset_o          holds the CPU in reset except when DONE
//   done_o / error_o     load verified / load rejected
module program_loader (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_start_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       mem_we_o,
    output logic [3:0] mem_addr_o,
    output logic [3:0] mem_wdata_o,
    output logic       cpu_reset_o,
    output logic       done_o,
    output logic       error_o
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LEN   = 4'd1;
    localparam logic [3:0] S_RECV  = 4'd2;
    localparam logic [3:0] S_WR_LO = 4'd3;
    localparam logic [3:0] S_WR_HI = 4'd4;
    localparam logic [3:0] S_CHK   = 4'd5;
    localparam logic [3:0] S_FILL  = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    logic [3:0] state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] xsum_q, xsum_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] faddr_q, faddr_d;
    logic       accept;

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        xsum_d  = xsum_q;
        hold_d  = hold_q;
        faddr_d = faddr_q;
        case (state_q)
            S_IDLE: begin
                if (load_start_i) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data_i == 8'd0 || in_data_i > 8'd8) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = in_data_i[3:0];
                        cnt_d   = 3'd0;
                        xsum_d  = 8'd0;
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    hold_d  = in_data_i;
                    xsum_d  = xsum_q ^ in_data_i;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                // cnt wraps 7->0 on the eighth byte; len==8 routes to CHK first
                cnt_d = cnt_q + 3'd1;
                if ({1'b0, cnt_q} + 4'd1 == len_q) state_d = S_CHK;
                else                               state_d = S_RECV;
            end
            S_CHK: begin
                if (accept) begin
                    if (in_data_i != xsum_q) begin
                        state_d = S_ERR;
                    end else if (len_q == 4'd8) begin
                        state_d = S_DONE;
                    end else begin
                        faddr_d = {len_q[2:0], 1'b0};
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // Address 15 is the final pad write; hold there instead of wrapping
                if (faddr_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    faddr_d = faddr_q + 4'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (load_start_i) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            len_q   <= 4'd0;
            cnt_q   <= 3'd0;
            xsum_q  <= 8'd0;
            hold_q  <= 8'd0;
            faddr_q <= 4'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            xsum_q  <= xsum_d;
            hold_q  <= hold_d;
            faddr_q <= faddr_d;
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        in_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 4'd0;
        mem_wdata_o = 4'd0;
        cpu_reset_o = 1'b1;
        done_o      = 1'b0;
        error_o     = 1'b0;
        case (state_q)
            S_LEN, S_RECV, S_CHK: in_ready_o = 1'b1;
            S_WR_LO: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {cnt_q, 1'b0};
                mem_wdata_o = hold_q[3:0];
            end
            S_WR_HI: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {cnt_q, 1'b1};
                mem_wdata_o = hold_q[7:4];
            end
            S_FILL: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = faddr_q;
            end
            S_DONE: begin
                done_o      = 1'b1;
                cpu_reset_o = 1'b0;
            end
            S_ERR: error_o = 1'b1;
            default: ;
        endcase
    end

endmodule
